// File: rtl/spi_flash_responder_if.sv
// SPI slave pins plus the backing-memory read port of the flash responder.
// slave: responder view; master: SPI host + memory model view.
// Memory returns mem_rdata exactly one clk after a mem_rd strobe.
interface spi_flash_responder_if;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        cmd_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, busy, cmd_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash responder: READ, FAST_READ and RDID over a 1-clk-latency memory.
// Latency: pins pass 2-flop synchronizers, so each sclk edge acts 2-3 clk after it occurs.
// No backpressure: clk must run >= 8x sclk so one prefetch always lands before it is needed.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter bit          CMD_FAST_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_flash_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  // Synchronizers and edge detection
  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_rise, sclk_fall, cs_n_s, cs_fall, mosi_s;

  // Two-flop synchronizers plus one history flop per edge-detected pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  // Sync flops reset to 0, so a cs_n held low across reset release never
  // looks like a falling edge: a fresh high-then-low is needed to start.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_n_s    = cs_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_n_s;
  assign mosi_s    = mosi_sync_q[1];

  // Protocol state
  state_t      state_q;
  logic [4:0]  bit_cnt_q;
  logic [22:0] shift_q;
  logic        fast_q;
  logic        id_mode_q;
  logic [23:0] addr_q;      // next address to prefetch
  logic [7:0]  buf_q;       // prefetched next byte
  logic [7:0]  tx_q;        // byte currently on miso
  logic [2:0]  bit_idx_q;   // bit driven on the next sclk fall
  logic [1:0]  id_idx_q;
  logic        rd_ack_q;    // memory data valid this clk
  logic        miso_q;
  logic        miso_oe_q;
  logic [23:0] mem_addr_q;
  logic        mem_rd_q;
  logic        busy_q;
  logic        cmd_err_q;

  logic [7:0]  opcode;
  logic [23:0] addr_full;
  logic [7:0]  id_byte;
  logic [7:0]  cur_byte;

  assign opcode    = {shift_q[6:0], mosi_s};
  assign addr_full = {shift_q, mosi_s};

  // Select the JEDEC ID byte for the current position in the 3-byte cycle.
  always_comb begin
    id_byte = JEDEC_ID[7:0];
    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase
  end

  assign cur_byte = id_mode_q ? id_byte : buf_q;

  // Main FSM with registered outputs; cs_n high overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 23'd0;
      fast_q     <= 1'b0;
      id_mode_q  <= 1'b0;
      addr_q     <= 24'd0;
      buf_q      <= 8'd0;
      tx_q       <= 8'd0;
      bit_idx_q  <= 3'd0;
      id_idx_q   <= 2'd0;
      rd_ack_q   <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      mem_addr_q <= 24'd0;
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      mem_rd_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      rd_ack_q  <= mem_rd_q;
      if (rd_ack_q) buf_q <= bus.mem_rdata;

      if (state_q != S_IDLE && cs_n_s) begin
        // Abort: discard partial work and any read still in flight.
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        miso_q    <= 1'b0;
        rd_ack_q  <= 1'b0;
        bit_cnt_q <= 5'd0;
        shift_q   <= 23'd0;
        fast_q    <= 1'b0;
        id_mode_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_fall) begin
              state_q   <= S_CMD;
              busy_q    <= 1'b1;
              bit_cnt_q <= 5'd0;
              shift_q   <= 23'd0;
              bit_idx_q <= 3'd7;
              id_idx_q  <= 2'd0;
              fast_q    <= 1'b0;
              id_mode_q <= 1'b0;
            end
          end

          S_CMD: begin
            if (sclk_rise) begin
              shift_q   <= {shift_q[21:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= 5'd0;
                shift_q   <= 23'd0;
                if (opcode == 8'h03) begin
                  state_q <= S_ADDR;
                end else if (CMD_FAST_EN && opcode == 8'h0B) begin
                  state_q <= S_ADDR;
                  fast_q  <= 1'b1;
                end else if (opcode == 8'h9F) begin
                  state_q   <= S_DATA;
                  id_mode_q <= 1'b1;
                  miso_oe_q <= 1'b1;
                end else begin
                  state_q   <= S_IGNORE;
                  cmd_err_q <= 1'b1;
                end
              end
            end
          end

          S_ADDR: begin
            if (sclk_rise) begin
              shift_q   <= {shift_q[21:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd23) begin
                // First byte is fetched now so it is ready by the first fall.
                bit_cnt_q  <= 5'd0;
                shift_q    <= 23'd0;
                mem_addr_q <= addr_full;
                addr_q     <= addr_full + 24'd1;
                mem_rd_q   <= 1'b1;
                state_q    <= fast_q ? S_DUMMY : S_DATA;
                miso_oe_q  <= ~fast_q;
              end
            end
          end

          S_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= 5'd0;
                state_q   <= S_DATA;
                miso_oe_q <= 1'b1;
              end
            end
          end

          S_DATA: begin
            if (sclk_fall) begin
              if (bit_idx_q == 3'd7) begin
                // Load the next byte and immediately prefetch the one after.
                miso_q <= cur_byte[7];
                tx_q   <= cur_byte;
                if (id_mode_q) begin
                  id_idx_q <= (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                end else begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= addr_q;
                  addr_q     <= addr_q + 24'd1;
                end
              end else begin
                miso_q <= tx_q[bit_idx_q];
              end
              bit_idx_q <= bit_idx_q - 3'd1;
            end
          end

          S_IGNORE: begin
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule
